// File: rtl/prelude_pkg.sv
// Shared types for the prelude core fetch path: opcode classes, fetch FSM
// states, PC update commands and the opcode decode helper.
package prelude_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Instruction class carried in the top two bits of every program byte
    typedef enum logic [1:0] {
        OP_IMM  = 2'd0,
        OP_CALC = 2'd1,
        OP_COPY = 2'd2,
        OP_COND = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // PC update request; LOAD (redirect) always outranks INC
    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_cmd_e;

    function automatic op_e decode_op(input logic [DATA_W-1:0] byte_in);
        return op_e'(byte_in[DATA_W-1 -: 2]);
    endfunction

endpackage

// File: rtl/prelude_pc.sv
// Program counter for the prelude fetch unit. Holds, increments with 8-bit
// wrap, or loads a redirect target. Asynchronous active-high reset.
module prelude_pc
    import prelude_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  pc_cmd_e           cmd_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC selection from the command
    always_comb begin
        pc_d = pc_q;
        case (cmd_i)
            PC_INC:  pc_d = pc_q + 1'b1;
            PC_LOAD: pc_d = load_val_i;
            default: pc_d = pc_q;
        endcase
    end

    // PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/prelude_fetch_ctrl.sv
// Fetch controller for the prelude core. Drives the combinational program
// ROM from the PC, captures the returned byte into a one-entry slot and
// hands it to execute over valid/ready. Execute may redirect the PC at any
// time; a redirect flushes the slot.
// Optional build macro PRELUDE_STEP_EN: adds a 'step' input so that in RUN
// only one instruction is fetched per cycle with step=1.
module prelude_fetch_ctrl
    import prelude_pkg::*;
#(
    parameter int                PROG_LEN = 256,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
`ifdef PRELUDE_STEP_EN
    input  logic              step,
`endif
    input  logic              start,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output op_e               instr_op,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              halted
);

    // A full 256-word program simply wraps, so the end-of-program stop only
    // exists for shorter programs.
    localparam bit                AUTO_HALT_EN = (PROG_LEN < 256);
    localparam logic [ADDR_W-1:0] END_PC       = ADDR_W'(PROG_LEN % 256);

    fetch_state_e      state_q, state_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    // Set once the end-of-program stop has fired at the current PC, so that
    // a later start resumes fetching from PROG_LEN instead of stopping again.
    logic              end_done_q, end_done_d;

    logic [ADDR_W-1:0] pc;
    pc_cmd_e           pc_cmd;
    logic              step_ok;
    logic              at_end;
    logic              end_halt;
    logic              fetch_en;

`ifdef PRELUDE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    assign at_end   = AUTO_HALT_EN && (pc == END_PC) && !end_done_q;
    assign end_halt = (state_q == RUN) && at_end && !br_valid;
    // A capture needs a free slot, or one being drained this same cycle
    assign fetch_en = (state_q == RUN) && !br_valid && !at_end && step_ok
                      && (!valid_q || instr_ready);

    prelude_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .cmd_i      (pc_cmd),
        .load_val_i (br_target),
        .pc_o       (pc)
    );

    // FSM next state; halt_req outranks start in HALT
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (halt_req || end_halt) state_d = HALT;
            HALT: if (start && !halt_req) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // End-of-program marker: armed on the stop, released once the PC moves on
    always_comb begin
        end_done_d = end_done_q;
        if (br_valid) begin
            end_done_d = 1'b0;
        end else if (end_halt) begin
            end_done_d = 1'b1;
        end else if (pc != END_PC) begin
            end_done_d = 1'b0;
        end
    end

    // Slot update and PC command; a redirect beats both capture and accept
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        pc_cmd  = PC_HOLD;
        if (br_valid) begin
            valid_d = 1'b0;
            pc_cmd  = PC_LOAD;
        end else if (fetch_en) begin
            valid_d = 1'b1;
            instr_d = rom_data;
            ipc_d   = pc;
            pc_cmd  = PC_INC;
        end else if (valid_q && instr_ready) begin
            valid_d = 1'b0;
        end
    end

    // FSM state and slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            ipc_q      <= '0;
            end_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
            end_done_q <= end_done_d;
        end
    end

    assign rom_addr    = pc;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_op    = decode_op(instr_q);
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_prelude_fetch_ctrl.sv
// Directed bench for prelude_fetch_ctrl with a short program (PROG_LEN=18).
module tb_prelude_fetch_ctrl;
    import prelude_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic       halt_req;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    op_e        instr_op;
    logic       br_valid;
    logic [7:0] br_target;
    logic       halted;
`ifdef PRELUDE_STEP_EN
    logic       step;
`endif

    logic [7:0] rom [256];
    assign rom_data = rom[rom_addr];

    prelude_fetch_ctrl #(
        .PROG_LEN (18),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef PRELUDE_STEP_EN
        .step        (step),
`endif
        .start       (start),
        .halt_req    (halt_req),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_op    (instr_op),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       halt_req;
        logic       ready;
        logic       br;
        logic [7:0] tgt;
        logic       exp_valid;
        logic [7:0] exp_instr;
        logic [7:0] exp_pc;
        logic [7:0] exp_addr;
        logic       exp_halted;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input logic s, input logic h, input logic r, input logic b,
                       input logic [7:0] t, input logic ev, input logic [7:0] ei,
                       input logic [7:0] ep, input logic [7:0] ea, input logic eh);
        vec_t v;
        v.start = s; v.halt_req = h; v.ready = r; v.br = b; v.tgt = t;
        v.exp_valid = ev; v.exp_instr = ei; v.exp_pc = ep; v.exp_addr = ea;
        v.exp_halted = eh;
        vecs.push_back(v);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; halt_req = 1'b0; instr_ready = 1'b1;
        br_valid = 1'b0; br_target = 8'h00;
    endtask

    initial begin
        logic [7:0] step_exp [3];
        logic [7:0] op_exp;

        // Maze program fragment; unlisted words are filler 0x20+i
        for (int i = 0; i < 256; i++) rom[i] = 8'(8'h20 + i);
        rom[0] = 8'h01; rom[1] = 8'h82; rom[2] = 8'h00;
        rom[9] = 8'hC1; rom[17] = 8'hC4;

        // Startup, stall, redirect, end-of-program stop, resume, halt_req, drain
        add(1,0,1,0,8'h00, 0,8'h00,8'h00,8'd0, 0);
        add(0,0,1,0,8'h00, 1,8'h01,8'h00,8'd1, 0);
        add(0,0,1,0,8'h00, 1,8'h82,8'h01,8'd2, 0);
        add(0,0,0,0,8'h00, 1,8'h82,8'h01,8'd2, 0);
        add(0,0,0,0,8'h00, 1,8'h82,8'h01,8'd2, 0);
        add(0,0,0,0,8'h00, 1,8'h82,8'h01,8'd2, 0);
        add(0,0,1,0,8'h00, 1,8'h00,8'h02,8'd3, 0);
        add(0,0,1,0,8'h00, 1,rom[3],8'h03,8'd4, 0);
        add(0,0,1,1,8'h09, 0,8'h00,8'h00,8'd9, 0);
        add(0,0,1,0,8'h00, 1,8'hC1,8'h09,8'd10, 0);
        for (int i = 10; i <= 17; i++)
            add(0,0,1,0,8'h00, 1,rom[i],8'(i),8'(i+1), 0);
        add(0,0,1,0,8'h00, 0,8'h00,8'h00,8'd18, 1);
        add(0,0,1,0,8'h00, 0,8'h00,8'h00,8'd18, 1);
        add(1,0,1,0,8'h00, 0,8'h00,8'h00,8'd18, 0);
        add(0,0,1,0,8'h00, 1,rom[18],8'd18,8'd19, 0);
        add(0,1,1,0,8'h00, 1,rom[19],8'd19,8'd20, 1);
        add(1,1,0,0,8'h00, 1,rom[19],8'd19,8'd20, 1);
        add(0,0,1,0,8'h00, 0,8'h00,8'h00,8'd20, 1);

        idle_inputs();
`ifdef PRELUDE_STEP_EN
        step = 1'b1;
`endif
        rst = 1'b1;
        #12;
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr", 32'(instr), 32'd0);
        chk("reset_instr_pc", 32'(instr_pc), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        cycle();

        foreach (vecs[k]) begin
            start = vecs[k].start; halt_req = vecs[k].halt_req;
            instr_ready = vecs[k].ready; br_valid = vecs[k].br;
            br_target = vecs[k].tgt;
            cycle();
            $display("vec %0d: valid=%0b instr=%02h pc=%02h op=%0d addr=%02h halted=%0b",
                     k, instr_valid, instr, instr_pc, instr_op, rom_addr, halted);
            chk($sformatf("vec%0d_valid", k), 32'(instr_valid), 32'(vecs[k].exp_valid));
            chk($sformatf("vec%0d_rom_addr", k), 32'(rom_addr), 32'(vecs[k].exp_addr));
            chk($sformatf("vec%0d_halted", k), 32'(halted), 32'(vecs[k].exp_halted));
            if (vecs[k].exp_valid) begin
                op_exp = vecs[k].exp_instr;
                chk($sformatf("vec%0d_instr", k), 32'(instr), 32'(vecs[k].exp_instr));
                chk($sformatf("vec%0d_instr_pc", k), 32'(instr_pc), 32'(vecs[k].exp_pc));
                chk($sformatf("vec%0d_op", k), 32'(instr_op), 32'(op_exp[7:6]));
            end
        end
        idle_inputs();

        // Asynchronous reset between edges while running
        start = 1'b1; cycle(); start = 1'b0;
        cycle(); cycle();
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        chk("pre_rst_instr_pc", 32'(instr_pc), 32'd21);
        #2 rst = 1'b1;
        #1;
        $display("async rst: valid=%0b addr=%02h halted=%0b", instr_valid, rom_addr, halted);
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("async_rst_halted", 32'(halted), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            $display("post rst idle %0d: valid=%0b addr=%02h", i, instr_valid, rom_addr);
            chk($sformatf("post_rst_idle%0d_valid", i), 32'(instr_valid), 32'd0);
            chk($sformatf("post_rst_idle%0d_addr", i), 32'(rom_addr), 32'd0);
        end
        start = 1'b1; cycle(); start = 1'b0;
        cycle();
        $display("restart: valid=%0b instr=%02h pc=%02h", instr_valid, instr, instr_pc);
        chk("restart_valid", 32'(instr_valid), 32'd1);
        chk("restart_instr", 32'(instr), 32'h01);
        chk("restart_instr_pc", 32'(instr_pc), 32'd0);

`ifdef PRELUDE_STEP_EN
        // Single-step: one fetch per step pulse, nothing in between
        step_exp[0] = 8'h01; step_exp[1] = 8'h82; step_exp[2] = 8'h00;
        step = 1'b0;
        rst = 1'b1; #3; rst = 1'b0;
        start = 1'b1; cycle(); start = 1'b0;
        cycle();
        chk("step_none_without_pulse", 32'(instr_valid), 32'd0);
        for (int p = 0; p < 3; p++) begin
            step = 1'b1; cycle(); step = 1'b0;
            $display("step %0d: valid=%0b instr=%02h pc=%02h", p, instr_valid, instr, instr_pc);
            chk($sformatf("step%0d_valid", p), 32'(instr_valid), 32'd1);
            chk($sformatf("step%0d_instr", p), 32'(instr), 32'(step_exp[p]));
            chk($sformatf("step%0d_instr_pc", p), 32'(instr_pc), 32'(p));
            for (int g = 0; g < 3; g++) begin
                cycle();
                chk($sformatf("step%0d_gap%0d_valid", p, g), 32'(instr_valid), 32'd0);
                chk($sformatf("step%0d_gap%0d_addr", p, g), 32'(rom_addr), 32'(p + 1));
            end
        end
`else
        step_exp[0] = 8'h00;
        step_exp[1] = 8'h00;
        step_exp[2] = 8'h00;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
